// File: rtl/sfr_access_arbiter.sv
// Arbitrates the SFR file's single read/write port among pipeline, interrupt
// controller and debug requesters; 16-bit pair accesses issue as two atomic byte cycles.
module sfr_access_arbiter (
  input  logic        clock_i,
  input  logic        nreset_i,
  input  logic [2:0]  req_i,
  input  logic [2:0]  req_we_i,
  input  logic [2:0]  req_wide_i,
  input  logic [14:0] req_addr_i,
  input  logic [47:0] req_wdata_i,
  output logic [2:0]  done_o,
  output logic [2:0]  err_o,
  output logic [15:0] rdata_o,
  output logic [1:0]  sfr_wren_o,
  output logic [4:0]  sfr_wr_addr_o,
  output logic [4:0]  sfr_rd_addr_o,
  output logic [7:0]  sfr_write_data_o,
  input  logic [7:0]  sfr_read_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE_LO, ISSUE_HI, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  winner_q, winner_d;
  logic        we_q, we_d;
  logic        wide_q, wide_d;
  logic        rej_q, rej_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  lo_q, lo_d;
  // Set when requester 2 was the last of {1,2} served; reset value favours 1.
  logic        rr_last2_q, rr_last2_d;

  logic [1:0]  grant_id;
  logic        sel_we, sel_wide, sel_reject;
  logic [4:0]  sel_addr;
  logic [15:0] sel_wdata;

  always_comb begin
    grant_id = 2'd0;
    if (req_i[0])                  grant_id = 2'd0;
    else if (req_i[1] && req_i[2]) grant_id = rr_last2_q ? 2'd1 : 2'd2;
    else if (req_i[1])             grant_id = 2'd1;
    else                           grant_id = 2'd2;
  end

  assign sel_we    = req_we_i[grant_id];
  assign sel_wide  = req_wide_i[grant_id];
  assign sel_addr  = req_addr_i[5*grant_id +: 5];
  assign sel_wdata = req_wdata_i[16*grant_id +: 16];
  // Odd-aligned pairs and writes into the read-only input ports (28..31) are refused.
  assign sel_reject = (sel_wide && sel_addr[0]) || (sel_we && (sel_addr[4:2] == 3'b111));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    winner_d         = winner_q;
    we_d             = we_q;
    wide_d           = wide_q;
    rej_d            = rej_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    lo_d             = lo_q;
    rr_last2_d       = rr_last2_q;
    done_o           = 3'b000;
    err_o            = 3'b000;
    rdata_o          = 16'h0000;
    sfr_wren_o       = 2'b00;
    sfr_wr_addr_o    = 5'd0;
    sfr_rd_addr_o    = 5'd0;
    sfr_write_data_o = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          winner_d = grant_id;
          we_d     = sel_we;
          wide_d   = sel_wide;
          rej_d    = sel_reject;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          if (grant_id != 2'd0) rr_last2_d = (grant_id == 2'd2);
          state_d  = sel_reject ? DONE : ISSUE_LO;
        end
      end
      ISSUE_LO: begin
        if (we_q) begin
          sfr_wren_o       = 2'b01;
          sfr_wr_addr_o    = addr_q;
          sfr_write_data_o = wdata_q[7:0];
        end else begin
          sfr_wren_o    = 2'b10;
          sfr_rd_addr_o = addr_q;
        end
        state_d = wide_q ? ISSUE_HI : DONE;
      end
      ISSUE_HI: begin
        if (we_q) begin
          sfr_wren_o       = 2'b01;
          sfr_wr_addr_o    = addr_q + 5'd1;
          sfr_write_data_o = wdata_q[15:8];
        end else begin
          sfr_wren_o    = 2'b10;
          sfr_rd_addr_o = addr_q + 5'd1;
        end
        // The file's registered read returns the low byte during this cycle.
        lo_d    = sfr_read_data_i;
        state_d = DONE;
      end
      DONE: begin
        done_o[winner_q] = 1'b1;
        err_o[winner_q]  = rej_q;
        if (!rej_q && !we_q)
          rdata_o = wide_q ? {sfr_read_data_i, lo_q} : {8'h00, sfr_read_data_i};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock_i) begin
    if (!nreset_i) begin
      state_q    <= IDLE;
      winner_q   <= 2'd0;
      we_q       <= 1'b0;
      wide_q     <= 1'b0;
      rej_q      <= 1'b0;
      addr_q     <= 5'd0;
      wdata_q    <= 16'h0000;
      lo_q       <= 8'h00;
      rr_last2_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      we_q       <= we_d;
      wide_q     <= wide_d;
      rej_q      <= rej_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lo_q       <= lo_d;
      rr_last2_q <= rr_last2_d;
    end
  end

endmodule
